instr_reg_sched: RTL and testbench
==================================

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports req0_valid/req1_valid, input, 1, requester write request.
REQ-004 SHALL have ports req0_ready/req1_ready, output, 1, grant; a transfer occurs when valid and ready are both high.
REQ-005 SHALL have ports req0_opcode/req1_opcode, input, opcode_t; req0_op_a/req0_op_b/req1_op_a/req1_op_b, input, operand_t.
REQ-006 SHALL have port drain, input, 1, request to stop accepting writes until empty.
REQ-007 SHALL have port rd_req, input, 1, consumer read request.
REQ-008 SHALL have port rd_valid, output, 1, read_pointer addresses a valid entry this cycle.
REQ-009 SHALL have ports load_en (1), opcode (opcode_t), operand_a/operand_b (operand_t), write_pointer (address_t), read_pointer (address_t), all outputs driving instr_register.
REQ-010 SHALL have ports count (6 bits, output, occupancy 0..32), full and empty (1 each, output), and drained (1, output, pulse).

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-012 IDLE: SHALL go to RUN on the first cycle after reset deassertion.
REQ-013 RUN -> DRAIN: SHALL transition when drain=1.
REQ-014 DRAIN -> IDLE: SHALL transition when count==0 and SHALL pulse drained for 1 cycle on that transition.
REQ-015 Grants SHALL be combinational: at most one of req0_ready/req1_ready high, only in RUN with full=0.
REQ-016 Arbitration SHALL be round-robin: on contention, grant the requester not granted last; last-grant pointer resets to 1 so req0 wins first.
REQ-017 On a transfer the block SHALL register the granted opcode/operands onto opcode/operand_a/operand_b and assert load_en for exactly 1 cycle (1-cycle latency).
REQ-018 write_pointer SHALL advance by 1 on the cycle after each load_en and wrap 31->0.
REQ-019 A read SHALL be accepted when rd_req=1 and empty=0 in any state; read_pointer SHALL advance by 1 (wrap 31->0) and rd_valid SHALL be high whenever empty=0.
REQ-020 count SHALL increment per transfer, decrement per accepted read, and stay unchanged on a simultaneous transfer and read.
REQ-021 full SHALL be count==32 and empty SHALL be count==0, both derived from registered count.
REQ-022 A read in the same cycle as full=1 SHALL NOT enable a write that cycle.
REQ-023 rd_req with empty=1 SHALL be ignored with no pointer or count change.
REQ-024 In DRAIN, reads SHALL continue and all grants SHALL be 0.

Reset
REQ-025 On reset=1 at posedge clk the block SHALL clear to: state IDLE, load_en 0, opcode ZERO, operand_a/operand_b 0, write_pointer/read_pointer 0, count 0, empty 1, full 0, drained 0, last-grant 1.
REQ-026 Reset mid-transfer SHALL discard the transfer, with no load_en in the following cycle.
REQ-027 Grants SHALL be 0 while reset=1.

Configuration
REQ-028 With INSTR_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, req0 over req1, and the last-grant pointer SHALL be absent.
REQ-029 Without INSTR_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-016.

Structure
REQ-030 opcode_t, operand_t, address_t and the constant depth 32 SHALL come from instr_register_pkg.
REQ-031 The package SHALL add sched_state_t (IDLE, RUN, DRAIN).
REQ-032 Arbitration SHALL be one sub-module, instr_rr_arbiter (2 requests in, 2 one-hot grants out, advance input).

Verification
REQ-033 Reset then req0_valid=1 with ADD, op_a 5, op_b 3 -> req0_ready=1; next cycle load_en=1, opcode ADD, operand_a 5, operand_b 3, write_pointer 0; then write_pointer 1 and count 1.
REQ-034 Both valid for 4 cycles -> grants req0, req1, req0, req1 (fixed-prio build: req0 x4); count 4.
REQ-035 32 writes, no reads -> full=1 and grants 0; 33rd request stalls; a rd_req drops count to 31 and the write is granted the next cycle.
REQ-036 write_pointer at 31 plus a write -> it wraps to 0; read_pointer wraps likewise after 32 reads.
REQ-037 count 3, drain=1 with req0_valid held -> no grants; 3 reads -> count 0, drained pulse, state IDLE.
REQ-038 Reset asserted during a grant cycle -> no load_en afterward; all outputs equal REQ-025 values.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register and its write scheduler.
package instr_register_pkg;

    localparam int unsigned DEPTH     = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned COUNT_W   = 6;
    localparam int unsigned OPCODE_W  = 4;

    typedef enum logic [OPCODE_W-1:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic [ADDR_W-1:0]           address_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // One instruction as carried from a requester to the register file.
    typedef struct packed {
        opcode_t  opcode;
        operand_t op_a;
        operand_t op_b;
    } instr_t;

    // Circular pointer increment; the 5-bit width gives the 31 -> 0 wrap.
    function automatic address_t ptr_inc(input address_t p);
        return p + address_t'(1);
    endfunction

endpackage

// File: rtl/instr_rr_arbiter.sv
// Two-requester arbiter with one-hot grants.
// Round-robin by default; INSTR_SCHED_FIXED_PRIO_EN selects fixed priority (req[0] first).
module instr_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef INSTR_SCHED_FIXED_PRIO_EN

    logic unused_arb;
    assign unused_arb = ^{clk, reset, advance};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

`else

    // High when requester 1 won the most recent transfer.
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_gnt <= gnt[1];
        end
    end

`endif

endmodule

// File: rtl/instr_reg_sched.sv
// Write scheduler for instr_register: arbitrates two requesters, tracks occupancy and pointers,
// and supports drain-to-empty. INSTR_SCHED_FIXED_PRIO_EN switches the arbiter to fixed priority.
module instr_reg_sched
    import instr_register_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  opcode_t            req0_opcode,
    input  operand_t           req0_op_a,
    input  operand_t           req0_op_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  opcode_t            req1_opcode,
    input  operand_t           req1_op_a,
    input  operand_t           req1_op_b,
    input  logic               drain,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic               load_en,
    output opcode_t            opcode,
    output operand_t           operand_a,
    output operand_t           operand_b,
    output address_t           write_pointer,
    output address_t           read_pointer,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               drained
);

    sched_state_t       state;
    sched_state_t       state_next;
    logic               accept_c;
    logic [1:0]         req_c;
    logic [1:0]         gnt_c;
    logic               transfer_c;
    logic               rd_accept_c;
    logic [COUNT_W-1:0] count_next;
    instr_t             wr_instr_c;

    // Writes are taken only while running, not being asked to drain, and with room left.
    assign accept_c    = (state == RUN) && !drain && !full && !reset;
    assign req_c       = {req1_valid, req0_valid} & {2{accept_c}};
    assign transfer_c  = |gnt_c;
    assign rd_accept_c = rd_req && !empty;
    assign req0_ready  = gnt_c[0];
    assign req1_ready  = gnt_c[1];

    instr_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_c),
        .advance (transfer_c),
        .gnt     (gnt_c)
    );

    always_comb begin
        wr_instr_c = '{opcode: req0_opcode, op_a: req0_op_a, op_b: req0_op_b};
        if (gnt_c[1]) begin
            wr_instr_c = '{opcode: req1_opcode, op_a: req1_op_a, op_b: req1_op_b};
        end
    end

    always_comb begin
        count_next = count;
        case ({transfer_c, rd_accept_c})
            2'b10:   count_next = count + COUNT_W'(1);
            2'b01:   count_next = count - COUNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (drain) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered payload, pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en       <= 1'b0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            rd_valid      <= 1'b0;
            drained       <= 1'b0;
        end else begin
            load_en <= transfer_c;
            if (transfer_c) begin
                opcode    <= wr_instr_c.opcode;
                operand_a <= wr_instr_c.op_a;
                operand_b <= wr_instr_c.op_b;
            end
            // The pointer names the slot being loaded, so it moves after the load.
            if (load_en) begin
                write_pointer <= ptr_inc(write_pointer);
            end
            if (rd_accept_c) begin
                read_pointer <= ptr_inc(read_pointer);
            end
            count    <= count_next;
            full     <= (count_next == COUNT_W'(DEPTH));
            empty    <= (count_next == '0);
            rd_valid <= (count_next != '0);
            drained  <= (state == DRAIN) && (count == '0);
        end
    end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Self-checking bench for instr_reg_sched: table vectors, directed corner sequences, random vs model.
module tb_instr_reg_sched;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req0_valid, req1_valid, drain, rd_req;
    logic req0_ready, req1_ready, rd_valid, load_en, full, empty, drained;
    opcode_t req0_opcode, req1_opcode, opcode;
    operand_t req0_op_a, req0_op_b, req1_op_a, req1_op_b, operand_a, operand_b;
    address_t write_pointer, read_pointer;
    logic [5:0] count;

    instr_reg_sched dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .drain(drain), .rd_req(rd_req), .rd_valid(rd_valid),
        .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .count(count), .full(full), .empty(empty), .drained(drained)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = idle, 1 = run, 2 = drain; occupancy as a plain integer.
    int m_phase, m_count, m_wp, m_rp, m_last, m_opc, m_a, m_b;
    bit m_load, m_drained;

    typedef struct {
        bit v0; bit v1; bit e0; bit e1;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_grants(output bit g0, output bit g1);
        bit allow;
        g0 = 1'b0;
        g1 = 1'b0;
        allow = !reset && (m_phase == 1) && !drain && (m_count < 32);
        if (allow) begin
`ifdef INSTR_SCHED_FIXED_PRIO_EN
            g0 = req0_valid;
            g1 = req1_valid && !req0_valid;
`else
            if (req0_valid && req1_valid) begin
                g0 = (m_last == 1);
                g1 = (m_last == 0);
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
`endif
        end
    endtask

    // Check every output against the model, then advance one clock.
    task automatic step();
        bit g0, g1, rd;
        int n_phase;
        #1;
        exp_grants(g0, g1);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("load_en", load_en, m_load);
        chk("opcode", int'(opcode), m_opc);
        chk("operand_a", operand_a, m_a);
        chk("operand_b", operand_b, m_b);
        chk("write_pointer", write_pointer, m_wp);
        chk("read_pointer", read_pointer, m_rp);
        chk("count", count, m_count);
        chk("full", full, m_count == 32);
        chk("empty", empty, m_count == 0);
        chk("rd_valid", rd_valid, m_count != 0);
        chk("drained", drained, m_drained);
        rd = rd_req && (m_count > 0);
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_count = 0; m_wp = 0; m_rp = 0; m_last = 1;
            m_opc = 0; m_a = 0; m_b = 0; m_load = 0; m_drained = 0;
        end else begin
            if (m_load) m_wp = (m_wp + 1) % 32;
            if (rd) m_rp = (m_rp + 1) % 32;
            m_load = g0 | g1;
            if (g0) begin m_opc = int'(req0_opcode); m_a = req0_op_a; m_b = req0_op_b; end
            if (g1) begin m_opc = int'(req1_opcode); m_a = req1_op_a; m_b = req1_op_b; end
            if (g0 | g1) m_last = g1 ? 1 : 0;
            m_drained = (m_phase == 2) && (m_count == 0);
            n_phase = m_phase;
            if (m_phase == 0) n_phase = 1;
            else if (m_phase == 1 && drain) n_phase = 2;
            else if (m_phase == 2 && m_count == 0) n_phase = 0;
            m_phase = n_phase;
            m_count = m_count + int'(g0 | g1) - int'(rd);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; drain = 0; rd_req = 0;
        req0_opcode = ZERO; req1_opcode = ZERO;
        req0_op_a = 0; req0_op_b = 0; req1_op_a = 0; req1_op_b = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic randomize_payload();
        req0_opcode = opcode_t'($urandom_range(0, 7));
        req1_opcode = opcode_t'($urandom_range(0, 7));
        req0_op_a = operand_t'($urandom); req0_op_b = operand_t'($urandom);
        req1_op_a = operand_t'($urandom); req1_op_b = operand_t'($urandom);
    endtask

    vec_t tbl[6];

    initial begin
        reset = 1;
        idle_inputs();
        m_phase = 0; m_count = 0; m_wp = 0; m_rp = 0; m_last = 1;
        m_opc = 0; m_a = 0; m_b = 0; m_load = 0; m_drained = 0;
        @(negedge clk);
        do_reset();

        // Single transfer with its one-cycle load latency.
        req0_valid = 1; req0_opcode = ADD; req0_op_a = 5; req0_op_b = 3;
        #1 chk("first_ready", req0_ready, 1);
        step();
        idle_inputs();
        chk("first_load_en", load_en, 1);
        chk("first_opcode", int'(opcode), int'(ADD));
        chk("first_op_a", operand_a, 5);
        chk("first_op_b", operand_b, 3);
        chk("first_wp", write_pointer, 0);
        step();
        chk("first_wp_after", write_pointer, 1);
        chk("first_count", count, 1);

        // Contention vectors.
        do_reset();
`ifdef INSTR_SCHED_FIXED_PRIO_EN
        tbl[0] = '{1, 1, 1, 0}; tbl[1] = '{1, 1, 1, 0};
        tbl[2] = '{1, 1, 1, 0}; tbl[3] = '{1, 1, 1, 0};
`else
        tbl[0] = '{1, 1, 1, 0}; tbl[1] = '{1, 1, 0, 1};
        tbl[2] = '{1, 1, 1, 0}; tbl[3] = '{1, 1, 0, 1};
`endif
        tbl[4] = '{0, 1, 0, 1}; tbl[5] = '{1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            randomize_payload();
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            #1;
            chk($sformatf("tbl%0d_g0", i), req0_ready, tbl[i].e0);
            chk($sformatf("tbl%0d_g1", i), req1_ready, tbl[i].e1);
            step();
        end
        idle_inputs();
        step();
        chk("tbl_count", count, 6);

        // Fill to full, stall, free one slot by reading.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            randomize_payload();
            req0_valid = 1;
            step();
        end
        req0_valid = 0;
        step();
        chk("fill_full", full, 1);
        chk("fill_count", count, 32);
        chk("fill_wp_wrap", write_pointer, 0);
        req0_valid = 1;
        #1 chk("stall_ready", req0_ready, 0);
        step();
        rd_req = 1;
        #1 chk("stall_ready_rd", req0_ready, 0);
        step();
        rd_req = 0;
        chk("after_rd_count", count, 31);
        #1 chk("regrant_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        step();
        chk("refill_count", count, 32);
        chk("wp_33", write_pointer, 1);
        rd_req = 1;
        for (int i = 0; i < 32; i++) step();
        rd_req = 0;
        chk("rp_wrap", read_pointer, 1);
        chk("rd_empty", empty, 1);
        rd_req = 1;
        step();
        rd_req = 0;
        chk("empty_rd_ignored", read_pointer, 1);

        // Drain with a requester still pushing.
        do_reset();
        req0_valid = 1;
        for (int i = 0; i < 3; i++) step();
        drain = 1;
        #1 chk("drain_no_grant", req0_ready, 0);
        step();
        chk("drain_count", count, 3);
        rd_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("drain_rd_no_grant", req0_ready, 0);
            step();
        end
        rd_req = 0;
        chk("drain_count0", count, 0);
        step();
        chk("drained_pulse", drained, 1);
        step();
        chk("drained_clear", drained, 0);
        idle_inputs();
        step();

        // Reset arriving in a grant cycle.
        do_reset();
        req0_valid = 1; req0_opcode = SUB; req0_op_a = 9; req0_op_b = 4;
        #1 chk("pre_reset_ready", req0_ready, 1);
        reset = 1;
        #1 chk("reset_ready", req0_ready, 0);
        step();
        reset = 0;
        idle_inputs();
        chk("rst_load_en", load_en, 0);
        chk("rst_opcode", int'(opcode), int'(ZERO));
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wp", write_pointer, 0);
        step();
        chk("rst_load_en_next", load_en, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randomize_payload();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rd_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) drain = ~drain;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
